// File: rtl/game_fsm_p.sv
// Puzzle-round controller: IDLE/PLAY/WIN/LOSE with move and time limits, pause, restart, best score.
// All outputs registered, one cycle after the inputs are sampled; no backpressure, every input is sampled each cycle.
module game_fsm_p #(
    parameter int STEP_W     = 6,
    parameter int MAX_STEPS  = 63,
    parameter int TICK_DIV   = 100000000,
    parameter int TIME_W     = 8,
    parameter int TIME_LIMIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_sw,
    input  logic              win_flag,
    input  logic              active,
    input  logic              reset,
    input  logic              pause_sw,
    output logic [1:0]        game_s,
    output logic [STEP_W-1:0] ste_num,
    output logic [STEP_W-1:0] best_num,
    output logic [TIME_W-1:0] time_num,
    output logic              paused,
    output logic              win_pulse
);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_PLAY = 2'b01;
    localparam logic [1:0] S_WIN  = 2'b10;
    localparam logic [1:0] S_LOSE = 2'b11;

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [STEP_W-1:0] MAX_Q     = STEP_W'(MAX_STEPS);
    localparam logic [TIME_W-1:0] TLIM_Q    = TIME_W'(TIME_LIMIT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [1:0]        game_s_q, game_s_d;
    logic [STEP_W-1:0] ste_q, ste_d;
    logic [STEP_W-1:0] best_q, best_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              paused_q, paused_d;
    logic              win_pulse_q, win_pulse_d;
    logic              active_d_q;
    logic              step;

    assign step = active & ~active_d_q;

    always_comb begin
        game_s_d    = game_s_q;
        ste_d       = ste_q;
        best_d      = best_q;
        time_d      = time_q;
        tick_d      = tick_q;
        win_pulse_d = 1'b0;

        if (!st_sw) begin
            game_s_d = S_IDLE;
            ste_d    = '0;
            time_d   = '0;
            tick_d   = '0;
        end else if (game_s_q == S_IDLE || reset) begin
            game_s_d = S_PLAY;
            ste_d    = '0;
            time_d   = '0;
            tick_d   = '0;
        end else if (game_s_q == S_PLAY && !pause_sw) begin
            // A win outranks both limits; a step in the winning cycle is dropped.
            if (win_flag) begin
                game_s_d    = S_WIN;
                win_pulse_d = 1'b1;
                if (ste_q < best_q) begin
                    best_d = ste_q;
                end
            end else if (TIME_LIMIT != 0 && time_q == TLIM_Q) begin
                game_s_d = S_LOSE;
            end else if (step && ste_q == MAX_Q) begin
                game_s_d = S_LOSE;
            end else begin
                if (step) begin
                    ste_d = ste_q + 1'b1;
                end
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (time_q != '1) begin
                        time_d = time_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
        end

        paused_d = (game_s_d == S_PLAY) && pause_sw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            game_s_q    <= S_IDLE;
            ste_q       <= '0;
            best_q      <= '1;
            time_q      <= '0;
            tick_q      <= '0;
            paused_q    <= 1'b0;
            win_pulse_q <= 1'b0;
            active_d_q  <= 1'b0;
        end else begin
            game_s_q    <= game_s_d;
            ste_q       <= ste_d;
            best_q      <= best_d;
            time_q      <= time_d;
            tick_q      <= tick_d;
            paused_q    <= paused_d;
            win_pulse_q <= win_pulse_d;
            // Tracks active even while paused so a press held across resume is not counted.
            active_d_q  <= active;
        end
    end

    assign game_s    = game_s_q;
    assign ste_num   = ste_q;
    assign best_num  = best_q;
    assign time_num  = time_q;
    assign paused    = paused_q;
    assign win_pulse = win_pulse_q;

endmodule

// File: doc/game_fsm_p.md
Name: game_fsm_p

Overview:
- Parametrised successor to the game-control FSM. Sequences a puzzle round through IDLE, PLAY, WIN and LOSE.
- Counts player moves from an edge-detected `active` input and enforces a configurable move limit and round time limit.
- Supports pause and restart, and records the best (fewest-move) winning score.
- Sits between the input debouncers and the display/score logic in the top level.

Parameters:
- STEP_W, 6, width of move counter and best-score register.
- MAX_STEPS, 63, moves allowed per round; the move after MAX_STEPS loses. Range 1..2^STEP_W-1.
- TICK_DIV, 100000000, clock cycles per round-time tick (1 s at 100 MHz). Must be ≥2.
- TIME_W, 8, width of round-time counter.
- TIME_LIMIT, 0, ticks allowed per round; 0 disables the time limit.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- st_sw  in  1  start switch, level; 0 forces IDLE.
- win_flag  in  1  board-solved indication from the puzzle logic, level.
- active  in  1  move request; a 0→1 transition counts one move.
- reset  in  1  restart-round request, level; sampled each cycle.
- pause_sw  in  1  pause switch, level.
- game_s  out  2  state encoding: 00 IDLE, 01 PLAY, 10 WIN, 11 LOSE.
- ste_num  out  STEP_W  moves taken this round.
- best_num  out  STEP_W  fewest moves of any win since rst.
- time_num  out  TIME_W  elapsed ticks this round.
- paused  out  1  high while in PLAY with pause_sw=1.
- win_pulse  out  1  one-cycle pulse on the cycle game_s becomes WIN.

Behaviour:
- All outputs are registered.
- On rst=1 at a clk edge, the following hold from the next cycle:
  - game_s=00, ste_num=0, time_num=0, paused=0, win_pulse=0.
  - best_num=all ones.
  - Internal active_d=0, tick counter=0.
- rst mid-round discards the round; best_num is also reset.
- Move event: step = active & ~active_d. active_d is a one-cycle register of active. A held-high active counts exactly once.
- Priority per cycle, highest first: rst > st_sw=0 > reset > win_flag > limit checks > step/tick.
- st_sw=0 in any state:
  - game_s→IDLE next cycle.
  - ste_num and time_num cleared.
  - best_num kept.
- IDLE:
  - st_sw=1 → PLAY next cycle with ste_num=0, time_num=0, tick counter=0.
  - reset, win_flag, steps and pause_sw are ignored.
- reset=1 while in PLAY, WIN or LOSE (st_sw=1):
  - game_s→PLAY next cycle.
  - ste_num, time_num and tick counter cleared.
  - A step in the same cycle is discarded.
  - While reset stays high the round stays cleared.
- PLAY, not paused (pause_sw=0):
  - win_flag=1: game_s→WIN; win_pulse=1 for one cycle; best_num←min(best_num, ste_num). A step in the same cycle is not counted.
  - Move limit: step with ste_num==MAX_STEPS → LOSE; ste_num stays at MAX_STEPS.
  - Otherwise step → ste_num+1. ste_num never exceeds MAX_STEPS and never wraps.
  - Tick counter counts 0..TICK_DIV-1. On wrap, time_num+1, saturating at all ones.
  - Time limit: if TIME_LIMIT≠0 and time_num==TIME_LIMIT, → LOSE on the following cycle. Time limit and win_flag in the same cycle resolve to WIN.
- PLAY, paused (pause_sw=1):
  - paused=1.
  - Steps, tick counter, time_num, win_flag and limit checks are frozen or ignored.
  - active_d keeps tracking active, so a press made during pause is not counted after resume.
  - st_sw=0 and reset still act.
- WIN / LOSE:
  - Terminal; ste_num and time_num hold.
  - Exit only by reset (→PLAY) or st_sw=0 (→IDLE).
  - paused=0.
- Leaving PLAY clears paused on the next cycle.
- Outputs change one cycle after the causing input is sampled.

Test Plan:
Bench parameters: STEP_W=4, MAX_STEPS=5, TICK_DIV=4, TIME_LIMIT=3.
- Reset and start:
  - rst 1 cycle → game_s=00, ste_num=0, best_num=15, time_num=0.
  - st_sw=1 → game_s=01 next cycle.
- Move counting:
  - 3 separate active pulses → ste_num=3.
  - active held high 10 cycles → +1 only.
  - A press made while pause_sw=1 → not counted; time_num frozen; paused=1.
- Move limit: reach ste_num=5, then one more pulse → game_s=11, ste_num stays 5.
- Win and best score:
  - Win at ste_num=2 → game_s=10, win_pulse 1 cycle, best_num=2.
  - reset pulse → game_s=01, ste_num=0.
  - Win at 4 → best_num stays 2.
- Timeout:
  - No moves for 12 cycles in PLAY → time_num=3.
  - game_s=11 the cycle after.
- Simultaneous events:
  - win_flag and active edge in same cycle → WIN, ste_num unchanged.
  - reset and st_sw=0 together → IDLE.
  - rst mid-PLAY → all outputs at reset values, best_num=15.
